// File: rtl/bist_addr_gen_pkg.sv
// rtl/bist_addr_gen_pkg.sv - shared widths, FSM states and background constants for the BIST address generator
package bist_addr_gen_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [7:0] BG_SOLID = 8'h00;
  localparam logic [7:0] BG_CHECK = 8'h55;

endpackage

// File: rtl/bist_addr_gen_if.sv
// rtl/bist_addr_gen_if.sv - control strobes in, SRAM address/data/strobes out
interface bist_addr_gen_if
  import bist_addr_gen_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              mar_lr;
  logic              mar_c;
  logic              rev_out;
  logic              bg0;
  logic              bln_out;
  logic              c1;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] exp_data;
  logic              mem_ce;
  logic              mem_we;
  logic              elem_done;

  // BIST control unit side
  modport master (
    output mar_lr, mar_c, rev_out, bg0, bln_out, c1,
    input  addr, wdata, exp_data, mem_ce, mem_we, elem_done
  );

  // Address generator side
  modport slave (
    input  mar_lr, mar_c, rev_out, bg0, bln_out, c1,
    output addr, wdata, exp_data, mem_ce, mem_we, elem_done
  );
endinterface

// File: rtl/bist_bg_pattern.sv
// rtl/bist_bg_pattern.sv - data background word from address LSB, checkerboard select and invert
module bist_bg_pattern
  import bist_addr_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              addr0_i,
  input  logic              bg_i,
  input  logic              inv_i,
  output logic [DATA_W-1:0] pattern_o
);

  logic [DATA_W-1:0] base;

  // Checkerboard flips on odd words; the invert turns a march-0 background into march-1 data
  always_comb begin
    base      = bg_i ? ({(DATA_W/8){BG_CHECK}} ^ {DATA_W{addr0_i}})
                     : {(DATA_W/8){BG_SOLID}};
    pattern_o = base ^ {DATA_W{inv_i}};
  end

endmodule

// File: rtl/bist_addr_gen.sv
// rtl/bist_addr_gen.sv - march element address sequencer with registered SRAM strobes
module bist_addr_gen
  import bist_addr_gen_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic              clk,
  input logic              rst,
  bist_addr_gen_if.slave   bus
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              dir_q;
  logic              bg_q;
  logic              inv_q;
  logic              ce_q;
  logic              we_q;
  logic              done_q;
  logic              at_end;
  logic [DATA_W-1:0] pattern;

  // Next counted address and end-of-element detect for the latched direction
  always_comb begin
    addr_d = dir_q ? (addr_q - 1'b1) : (addr_q + 1'b1);
    at_end = dir_q ? (addr_q == '0) : (addr_q == ADDR_LAST);
  end

  // Element FSM: load beats count, the final count parks in DONE with a one-cycle elem_done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      dir_q   <= 1'b0;
      bg_q    <= 1'b0;
      inv_q   <= 1'b0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.mar_lr) begin
      state_q <= ST_ACTIVE;
      addr_q  <= bus.rev_out ? ADDR_LAST : '0;
      dir_q   <= bus.rev_out;
      bg_q    <= bus.bg0;
      inv_q   <= bus.bln_out;
      ce_q    <= 1'b1;
      we_q    <= bus.c1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          ce_q <= 1'b1;
          we_q <= bus.c1;
          if (bus.mar_c && at_end) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            done_q <= 1'b0;
            if (bus.mar_c) begin
              addr_q <= addr_d;
            end
          end
        end
        ST_DONE, ST_IDLE: begin
          ce_q   <= 1'b0;
          we_q   <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ce_q    <= 1'b0;
          we_q    <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  bist_bg_pattern #(
    .DATA_W (DATA_W)
  ) u_bg_pattern (
    .addr0_i   (addr_q[0]),
    .bg_i      (bg_q),
    .inv_i     (inv_q),
    .pattern_o (pattern)
  );

  assign bus.addr      = addr_q;
  assign bus.wdata     = pattern;
  assign bus.exp_data  = pattern;
  assign bus.mem_ce    = ce_q;
  assign bus.mem_we    = we_q;
  assign bus.elem_done = done_q;

endmodule

// File: tb/tb_bist_addr_gen.sv
// tb/tb_bist_addr_gen.sv - directed vector bench for bist_addr_gen
module tb_bist_addr_gen;

  typedef struct {
    logic       lr;
    logic       mc;
    logic       rv;
    logic       b;
    logic       iv;
    logic       w;
    logic [7:0] addr;
    logic [7:0] data;
    logic       ce;
    logic       we;
    logic       done;
  } vec_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  vec_t tbl [10];

  bist_addr_gen_if bus ();

  bist_addr_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_pat(input logic [7:0] a, input logic b, input logic iv);
    logic [7:0] base;
    base = b ? (8'h55 ^ {8{a[0]}}) : 8'h00;
    return base ^ {8{iv}};
  endfunction

  task automatic check(input string name, input logic [7:0] ea, input logic [7:0] ed,
                       input logic ece, input logic ewe, input logic edone);
    vectors++;
    if (bus.addr !== ea || bus.wdata !== ed || bus.exp_data !== ed ||
        bus.mem_ce !== ece || bus.mem_we !== ewe || bus.elem_done !== edone) begin
      miscompares++;
      $display("FAIL %s: got addr=%h wdata=%h exp_data=%h ce=%b we=%b done=%b, want addr=%h data=%h ce=%b we=%b done=%b",
               name, bus.addr, bus.wdata, bus.exp_data, bus.mem_ce, bus.mem_we, bus.elem_done,
               ea, ed, ece, ewe, edone);
    end
  endtask

  task automatic drive(input logic lr, input logic mc, input logic rv, input logic b,
                       input logic iv, input logic w);
    @(negedge clk);
    bus.mar_lr  = lr;
    bus.mar_c   = mc;
    bus.rev_out = rv;
    bus.bg0     = b;
    bus.bln_out = iv;
    bus.c1      = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.mar_lr  = 1'b0;
    bus.mar_c   = 1'b1;
    bus.rev_out = 1'b0;
    bus.bg0     = 1'b0;
    bus.bln_out = 1'b0;
    bus.c1      = 1'b1;

    // 1: asynchronous reset while mar_c toggles
    #5;
    rst       = 1'b0;
    bus.mar_c = 1'b0;
    #2;
    check("reset_async", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, i[0], 1'b0, 1'b0, 1'b0, 1'b1);
      check("reset_hold", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst       = 1'b1;
    bus.mar_c = 1'b0;

    // Table: short mixed sequences
    //            lr    mc    rv    b     iv    w     addr   data   ce    we    done
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h55, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'hAA, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'hAA, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h55, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hAA, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 8'h55, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].lr, tbl[i].mc, tbl[i].rv, tbl[i].b, tbl[i].iv, tbl[i].w);
      check($sformatf("table_%0d", i), tbl[i].addr, tbl[i].data, tbl[i].ce, tbl[i].we, tbl[i].done);
    end

    // 2: full ascending write element, solid background
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("asc_load", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 256; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("asc_count", i[7:0], 8'h00, 1'b1, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("asc_done", 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("asc_after", 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);

    // 3: full descending read element, inverted checkerboard
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("desc_load", 8'hFF, 8'h55, 1'b1, 1'b0, 1'b0);
    for (int i = 254; i >= 0; i--) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check("desc_count", i[7:0], exp_pat(i[7:0], 1'b1, 1'b1), 1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("desc_done", 8'h00, 8'hAA, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("desc_nowrap", 8'h00, 8'hAA, 1'b0, 1'b0, 1'b0);

    // 4: load and count together at addr 17 reloads
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 17; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("at_17", 8'd17, 8'hFF, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("load_wins", 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0);

    // 5: config changes mid-sweep are ignored
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 100; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("at_100", 8'd100, 8'h55, 1'b1, 1'b1, 1'b0);
    for (int i = 101; i <= 200; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      if (i == 101 || i == 102 || i == 200)
        check("cfg_ignored", i[7:0], exp_pat(i[7:0], 1'b1, 1'b0), 1'b1, 1'b1, 1'b0);
    end

    // 6: reset mid-element, then counts without a load do nothing
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("post_reset_idle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("post_reset_load", 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
